// File: rtl/pipe_hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = datapath side (drives hazard inputs), slave = controller side.
interface pipe_hazard_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic             re1_id;
   logic             re2_id;
   logic [4:0]       rs1_ex;
   logic [4:0]       rs2_ex;
   logic             valid_ex;
   logic             rf_we_ex;
   logic [1:0]       wd_sel_ex;
   logic [4:0]       wR_ex;
   logic             valid_mem;
   logic             rf_we_mem;
   logic [4:0]       wR_mem;
   logic             valid_wb;
   logic             rf_we_wb;
   logic [4:0]       wR_wb;
   logic             br_taken_ex;
   logic             dram_req;
   logic             dram_ack;
   logic             stall_pc;
   logic             stall_if_id;
   logic             stall_id_ex;
   logic             stall_ex_mem;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             flush_mem_wb;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             dram_err;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output rs1_id, rs2_id, re1_id, re2_id, rs1_ex, rs2_ex,
      output valid_ex, rf_we_ex, wd_sel_ex, wR_ex,
      output valid_mem, rf_we_mem, wR_mem, valid_wb, rf_we_wb, wR_wb,
      output br_taken_ex, dram_req, dram_ack,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
      input  flush_if_id, flush_id_ex, flush_mem_wb,
      input  fwd_a_sel, fwd_b_sel, dram_err, stall_cycles
   );

   modport slave (
      input  rs1_id, rs2_id, re1_id, re2_id, rs1_ex, rs2_ex,
      input  valid_ex, rf_we_ex, wd_sel_ex, wR_ex,
      input  valid_mem, rf_we_mem, wR_mem, valid_wb, rf_we_wb, wR_wb,
      input  br_taken_ex, dram_req, dram_ack,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
      output flush_if_id, flush_id_ex, flush_mem_wb,
      output fwd_a_sel, fwd_b_sel, dram_err, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline. Freezes the whole
// pipeline while data memory is outstanding, handles branch flushes and
// load-use bubbles, selects EX operand forwarding, and keeps a sticky memory
// timeout flag plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter logic [1:0]  WD_SEL_DRAM = 2'b01,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned CNT_W       = 16
) (
   input logic          clk,
   input logic          rst_n,
   pipe_hazard_if.slave hz_if
);

   typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

   // Last wait count tolerated before the access is declared lost.
   localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             dram_err_q, dram_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             freeze;
   logic             load_use;
   logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
   logic             flush_if_id, flush_id_ex, flush_mem_wb;
   logic [1:0]       fwd_a_sel, fwd_b_sel;

   // Forwarding source for one EX operand; MEM result beats WB, x0 never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       v_mem, we_mem,
                                          input logic [4:0] wr_mem,
                                          input logic       v_wb, we_wb,
                                          input logic [4:0] wr_wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (v_mem && we_mem && (wr_mem != 5'd0) && (wr_mem == rs)) begin
         sel = 2'b01;
      end else if (v_wb && we_wb && (wr_wb != 5'd0) && (wr_wb == rs)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StRun;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // FSM next state: track the outstanding memory access and its age.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         StRun: begin
            if (hz_if.dram_req && !hz_if.dram_ack) begin
               state_d    = StMemWait;
               wait_cnt_d = 8'd1;
            end
         end
         StMemWait: begin
            if (hz_if.dram_ack) begin
               state_d    = StRun;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == WaitLast) begin
               state_d = StErr;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         StErr: begin
            state_d = StErr;
         end
         default: begin
            state_d    = StRun;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // FSM outputs: freeze > branch flush > load-use bubble; forwarding always live.
   always_comb begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_mem_wb = 1'b0;
      fwd_a_sel    = 2'b00;
      fwd_b_sel    = 2'b00;
      // Entry cycle of a wait freezes too, so the MEM instruction is not lost.
      freeze   = (state_q != StRun) || (hz_if.dram_req && !hz_if.dram_ack);
      load_use = hz_if.valid_ex && hz_if.rf_we_ex && (hz_if.wd_sel_ex == WD_SEL_DRAM) &&
                 (hz_if.wR_ex != 5'd0) &&
                 ((hz_if.re1_id && (hz_if.rs1_id == hz_if.wR_ex)) ||
                  (hz_if.re2_id && (hz_if.rs2_id == hz_if.wR_ex)));
      if (rst_n) begin
         if (freeze) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
         end else if (hz_if.br_taken_ex) begin
            // ID holds a wrong-path instruction, so any load-use is moot.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end
         fwd_a_sel = fwd_sel(hz_if.rs1_ex, hz_if.valid_mem, hz_if.rf_we_mem, hz_if.wR_mem,
                             hz_if.valid_wb, hz_if.rf_we_wb, hz_if.wR_wb);
         fwd_b_sel = fwd_sel(hz_if.rs2_ex, hz_if.valid_mem, hz_if.rf_we_mem, hz_if.wR_mem,
                             hz_if.valid_wb, hz_if.rf_we_wb, hz_if.wR_wb);
      end
   end

   // Next value of the sticky error flag and the saturating stall counter.
   always_comb begin
      dram_err_d  = dram_err_q || (state_d == StErr);
      stall_cnt_d = stall_cnt_q;
      if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Error flag and stall counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dram_err_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         dram_err_q  <= dram_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz_if.stall_pc     = stall_pc;
   assign hz_if.stall_if_id  = stall_if_id;
   assign hz_if.stall_id_ex  = stall_id_ex;
   assign hz_if.stall_ex_mem = stall_ex_mem;
   assign hz_if.flush_if_id  = flush_if_id;
   assign hz_if.flush_id_ex  = flush_id_ex;
   assign hz_if.flush_mem_wb = flush_mem_wb;
   assign hz_if.fwd_a_sel    = fwd_a_sel;
   assign hz_if.fwd_b_sel    = fwd_b_sel;
   assign hz_if.dram_err     = dram_err_q;
   assign hz_if.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a vector table for the combinational decisions,
// hand-written multi-cycle sequences, then random traffic against a model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CW = 6;  // small counter so saturation is reachable
   localparam int unsigned TO = 16;
   localparam int          CntMax = (1 << CW) - 1;

   // Control outputs as {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
   //                     flush_if_id, flush_id_ex, flush_mem_wb}
   localparam logic [6:0] CNone = 7'b0000000;
   localparam logic [6:0] CLu   = 7'b1100010;
   localparam logic [6:0] CBr   = 7'b0000110;
   localparam logic [6:0] CFrz  = 7'b1111001;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_hazard_if #(.CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(
      .WD_SEL_DRAM(2'b01),
      .TIMEOUT    (TO),
      .CNT_W      (CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .hz_if(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [4:0] rs1_id, rs2_id;
      logic       re1, re2;
      logic [4:0] rs1_ex, rs2_ex;
      logic [1:0] wdsel;
      logic [4:0] wr_ex, wr_mem, wr_wb;
      logic       br, req, ack;
      logic [6:0] ctl;
      logic [1:0] fa, fb;
   } vec_t;

   vec_t vecs[12];

   // Model state: cycles spent frozen on the current access, error, stall count.
   int   m_wait;
   bit   m_err;
   int   m_cnt;

   function automatic vec_t mk(input logic [4:0] rs1_id, rs2_id, input logic re1, re2,
                               input logic [4:0] rs1_ex, rs2_ex, input logic [1:0] wdsel,
                               input logic [4:0] wr_ex, wr_mem, wr_wb,
                               input logic br, req, ack,
                               input logic [6:0] ctl, input logic [1:0] fa, fb);
      vec_t v;
      v = '{rs1_id, rs2_id, re1, re2, rs1_ex, rs2_ex, wdsel, wr_ex, wr_mem, wr_wb,
            br, req, ack, ctl, fa, fb};
      return v;
   endfunction

   function automatic logic [11:0] dut_outs();
      return {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
              bus.flush_if_id, bus.flush_id_ex, bus.flush_mem_wb,
              bus.fwd_a_sel, bus.fwd_b_sel, bus.dram_err};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rs1_id = '0; bus.rs2_id = '0; bus.re1_id = 1'b0; bus.re2_id = 1'b0;
      bus.rs1_ex = '0; bus.rs2_ex = '0;
      bus.valid_ex = 1'b0; bus.rf_we_ex = 1'b0; bus.wd_sel_ex = '0; bus.wR_ex = '0;
      bus.valid_mem = 1'b0; bus.rf_we_mem = 1'b0; bus.wR_mem = '0;
      bus.valid_wb = 1'b0; bus.rf_we_wb = 1'b0; bus.wR_wb = '0;
      bus.br_taken_ex = 1'b0; bus.dram_req = 1'b0; bus.dram_ack = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      nxt();
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic drive_vec(input vec_t v);
      bus.rs1_id = v.rs1_id; bus.rs2_id = v.rs2_id; bus.re1_id = v.re1; bus.re2_id = v.re2;
      bus.rs1_ex = v.rs1_ex; bus.rs2_ex = v.rs2_ex;
      bus.valid_ex = 1'b1; bus.rf_we_ex = 1'b1; bus.wd_sel_ex = v.wdsel; bus.wR_ex = v.wr_ex;
      bus.valid_mem = 1'b1; bus.rf_we_mem = 1'b1; bus.wR_mem = v.wr_mem;
      bus.valid_wb = 1'b1; bus.rf_we_wb = 1'b1; bus.wR_wb = v.wr_wb;
      bus.br_taken_ex = v.br; bus.dram_req = v.req; bus.dram_ack = v.ack;
   endtask

   // A load in EX whose destination x5 is read by ID through rs1.
   task automatic set_load_use_x5();
      bus.valid_ex = 1'b1; bus.rf_we_ex = 1'b1; bus.wd_sel_ex = 2'b01; bus.wR_ex = 5'd5;
      bus.rs1_id = 5'd5; bus.re1_id = 1'b1;
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      if (bus.valid_mem && bus.rf_we_mem && bus.wR_mem == rs) return 2'b01;
      if (bus.valid_wb && bus.rf_we_wb && bus.wR_wb == rs) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [11:0] model_out();
      bit         frz, lu;
      logic [6:0] ctl;
      if (!rst_n) return 12'h000;
      frz = m_err || (m_wait > 0) || (bus.dram_req && !bus.dram_ack);
      lu  = bus.valid_ex && bus.rf_we_ex && bus.wd_sel_ex == 2'b01 && bus.wR_ex != 5'd0 &&
            ((bus.re1_id && bus.rs1_id == bus.wR_ex) || (bus.re2_id && bus.rs2_id == bus.wR_ex));
      if (frz)                  ctl = CFrz;
      else if (bus.br_taken_ex) ctl = CBr;
      else if (lu)              ctl = CLu;
      else                      ctl = CNone;
      return {ctl, m_fwd(bus.rs1_ex), m_fwd(bus.rs2_ex), m_err};
   endfunction

   task automatic model_reset();
      m_wait = 0;
      m_err  = 1'b0;
      m_cnt  = 0;
   endtask

   // Advance the model across one clock edge with the current inputs.
   task automatic model_step(input logic [11:0] exp);
      if (exp[11] && m_cnt < CntMax) m_cnt++;
      if (!m_err) begin
         if (m_wait > 0 && bus.dram_ack) begin
            m_wait = 0;
         end else if (m_wait > 0 || (bus.dram_req && !bus.dram_ack)) begin
            m_wait++;
            if (m_wait == TO) begin
               m_err  = 1'b1;
               m_wait = 0;
            end
         end
      end
   endtask

   initial begin
      logic [11:0] exp;
      //               rs1_id rs2_id re1 re2 rs1_ex rs2_ex wdsel wr_ex wr_mem wr_wb br req ack ctl fa fb
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, CNone, 2'b00, 2'b00);
      vecs[1]  = mk(5, 0, 1, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0, CLu,   2'b00, 2'b00);
      vecs[2]  = mk(0, 5, 0, 1, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0, CLu,   2'b00, 2'b00);
      vecs[3]  = mk(0, 5, 1, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0, CNone, 2'b00, 2'b00);
      vecs[4]  = mk(0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, CNone, 2'b00, 2'b00);
      vecs[5]  = mk(5, 0, 1, 0, 0, 0, 2'b00, 5, 0, 0, 0, 0, 0, CNone, 2'b00, 2'b00);
      vecs[6]  = mk(5, 0, 1, 0, 0, 0, 2'b01, 5, 0, 0, 1, 0, 0, CBr,   2'b00, 2'b00);
      vecs[7]  = mk(0, 0, 0, 0, 7, 3, 2'b00, 0, 3, 3, 0, 0, 0, CNone, 2'b00, 2'b01);
      vecs[8]  = mk(0, 0, 0, 0, 3, 3, 2'b00, 0, 0, 3, 0, 0, 0, CNone, 2'b10, 2'b10);
      vecs[9]  = mk(0, 0, 0, 0, 4, 9, 2'b00, 0, 9, 4, 0, 0, 0, CNone, 2'b10, 2'b01);
      vecs[10] = mk(5, 0, 1, 0, 0, 0, 2'b01, 5, 0, 0, 0, 1, 1, CLu,   2'b00, 2'b00);
      vecs[11] = mk(5, 0, 1, 0, 3, 0, 2'b01, 5, 3, 0, 1, 1, 0, CFrz,  2'b01, 2'b00);

      // Reset state, including with hazard-looking inputs applied.
      idle();
      rst_n = 1'b0;
      #2;
      check("reset_outs", dut_outs(), 12'h000);
      check("reset_cnt", bus.stall_cycles, 0);
      set_load_use_x5();
      bus.br_taken_ex = 1'b1;
      bus.dram_req    = 1'b1;
      #1;
      check("reset_outs_busy", dut_outs(), 12'h000);
      do_reset();

      // Table: every vector is checked in RUN, then inputs go idle before the edge.
      for (int i = 0; i < 12; i++) begin
         drive_vec(vecs[i]);
         #1;
         check($sformatf("vec%0d", i), dut_outs(), {vecs[i].ctl, vecs[i].fa, vecs[i].fb, 1'b0});
         idle();
         nxt();
      end

      // Load-use lasts one cycle, then the load forwards from WB.
      do_reset();
      set_load_use_x5();
      #1;
      check("lu_cyc0", dut_outs(), {CLu, 4'b0000, 1'b0});
      nxt();
      idle();
      bus.rs1_id = 5'd5; bus.re1_id = 1'b1;
      bus.valid_mem = 1'b1; bus.rf_we_mem = 1'b1; bus.wR_mem = 5'd5;
      #1;
      check("lu_cyc1", dut_outs(), {CNone, 4'b0000, 1'b0});
      nxt();
      idle();
      bus.rs1_ex = 5'd5;
      bus.valid_wb = 1'b1; bus.rf_we_wb = 1'b1; bus.wR_wb = 5'd5;
      #1;
      check("lu_fwd_wb", dut_outs(), {CNone, 2'b10, 2'b00, 1'b0});

      // Memory access acknowledged in the third cycle.
      do_reset();
      bus.dram_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.dram_ack = (k == 2);
         #1;
         check($sformatf("memwait%0d", k), dut_outs(), {CFrz, 4'b0000, 1'b0});
         nxt();
      end
      idle();
      #1;
      check("memwait_done", dut_outs(), {CNone, 4'b0000, 1'b0});
      check("memwait_cnt", bus.stall_cycles, 3);

      // Reset in the middle of a memory wait.
      nxt();
      bus.dram_req = 1'b1;
      nxt();
      set_load_use_x5();
      bus.br_taken_ex = 1'b1;
      #1;
      check("midwait_frozen", dut_outs(), {CFrz, 4'b0000, 1'b0});
      rst_n = 1'b0;
      #1;
      check("midwait_rst_outs", dut_outs(), 12'h000);
      check("midwait_rst_cnt", bus.stall_cycles, 0);
      nxt();
      idle();
      rst_n = 1'b1;
      bus.dram_req = 1'b1; bus.dram_ack = 1'b1;
      #1;
      check("after_rst_run", dut_outs(), {CNone, 4'b0000, 1'b0});
      check("after_rst_cnt", bus.stall_cycles, 0);

      // Timeout: 16 frozen cycles without ack, then sticky error.
      do_reset();
      bus.dram_req = 1'b1;
      for (int k = 0; k < TO; k++) begin
         #1;
         check($sformatf("to_wait%0d", k), dut_outs(), {CFrz, 4'b0000, 1'b0});
         nxt();
      end
      #1;
      check("to_err", dut_outs(), {CFrz, 4'b0000, 1'b1});
      bus.dram_ack = 1'b1;
      nxt();
      nxt();
      check("to_err_ack", dut_outs(), {CFrz, 4'b0000, 1'b1});
      for (int k = 0; k < 50; k++) nxt();
      check("cnt_saturate", bus.stall_cycles, CntMax);
      rst_n = 1'b0;
      #1;
      check("to_rst_outs", dut_outs(), 12'h000);
      nxt();
      idle();
      rst_n = 1'b1;
      #1;
      check("to_rst_run", dut_outs(), {CNone, 4'b0000, 1'b0});

      // Random traffic against the model, with occasional resets.
      do_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         rst_n = ($urandom_range(0, 79) != 0);
         bus.rs1_id = 5'($urandom_range(0, 3));  bus.rs2_id = 5'($urandom_range(0, 3));
         bus.re1_id = 1'($urandom_range(0, 1));  bus.re2_id = 1'($urandom_range(0, 1));
         bus.rs1_ex = 5'($urandom_range(0, 3));  bus.rs2_ex = 5'($urandom_range(0, 3));
         bus.valid_ex = 1'($urandom_range(0, 1)); bus.rf_we_ex = 1'($urandom_range(0, 1));
         bus.wd_sel_ex = 2'($urandom_range(0, 3)); bus.wR_ex = 5'($urandom_range(0, 3));
         bus.valid_mem = 1'($urandom_range(0, 1)); bus.rf_we_mem = 1'($urandom_range(0, 1));
         bus.wR_mem = 5'($urandom_range(0, 3));
         bus.valid_wb = 1'($urandom_range(0, 1)); bus.rf_we_wb = 1'($urandom_range(0, 1));
         bus.wR_wb = 5'($urandom_range(0, 3));
         bus.br_taken_ex = ($urandom_range(0, 4) == 0);
         bus.dram_req    = ($urandom_range(0, 3) == 0);
         bus.dram_ack    = ($urandom_range(0, 4) == 0);
         #1;
         if (!rst_n) model_reset();
         exp = model_out();
         check("rand_outs", dut_outs(), exp);
         check("rand_cnt", bus.stall_cycles, m_cnt);
         if (rst_n) model_step(exp);
         nxt();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It detects load-use and control hazards, selects operand forwarding sources for EX, and freezes the pipeline while data memory has not acknowledged an access. It drives the hold and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also keeps a sticky memory-timeout error flag and a saturating stall-cycle counter.

Parameters:
WD_SEL_DRAM, 2'b01, wd_sel code that marks a load (writeback from DRAM).
TIMEOUT, 16, maximum number of cycles spent waiting for dram_ack before an error is declared (range 2..255).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rs1_id, rs2_id  in  5 each  source registers of the instruction in ID
re1_id, re2_id  in  1 each  ID instruction actually reads rs1 / rs2
rs1_ex, rs2_ex  in  5 each  source registers of the instruction in EX
valid_ex, rf_we_ex  in  1 each  EX slot valid / writes the register file
wd_sel_ex  in  2  writeback select of the EX instruction
wR_ex  in  5  destination register of the EX instruction
valid_mem, rf_we_mem  in  1 each  MEM slot valid / writes the register file
wR_mem  in  5  destination register of the MEM instruction
valid_wb, rf_we_wb  in  1 each  WB slot valid / writes the register file
wR_wb  in  5  destination register of the WB instruction
br_taken_ex  in  1  branch/jump in EX redirects the PC this cycle
dram_req  in  1  MEM stage issues a load/store this cycle (valid only)
dram_ack  in  1  data memory completes the access this cycle
stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the corresponding register
flush_if_id, flush_id_ex, flush_mem_wb  out  1 each  load a bubble (valid=0, rf_we=0)
fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 register file, 01 EX/MEM alu_c, 10 WB write data
dram_err  out  1  sticky memory-timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1

Behaviour:
- Reset (rst_n low, asynchronous): state=RUN, wait counter=0, dram_err=0, stall_cycles=0.
  - While in reset, all stall and flush outputs are 0 and fwd_*_sel=00.
- FSM states: RUN, MEM_WAIT, ERR. Outputs are combinational from the state and the current inputs.
- RUN transitions:
  - dram_req=1 and dram_ack=0 -> MEM_WAIT, counter=1.
  - dram_req=1 and dram_ack=1 -> stay in RUN (no stall).
- MEM_WAIT behaviour:
  - Asserts all four stall_* and flush_mem_wb, so WB does not re-commit the instruction.
  - dram_ack=1 -> RUN, counter=0. The instruction is released into MEM/WB at that clock edge.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack, the FSM goes to ERR.
- ERR: all stall_* asserted, flush_mem_wb=1, dram_err=1. ERR is left only by reset.
- Priority, highest first:
  1. MEM_WAIT / ERR freeze. br_taken_ex and load-use are ignored; the EX instruction is held, so its redirect re-presents after the freeze.
  2. Branch: br_taken_ex=1 in RUN -> flush_if_id=1, flush_id_ex=1, no stall. A simultaneous load-use is suppressed because the ID instruction is on the wrong path.
  3. Load-use stall. Condition: valid_ex & rf_we_ex & wd_sel_ex==WD_SEL_DRAM & wR_ex!=0 & ((re1_id & rs1_id==wR_ex) | (re2_id & rs2_id==wR_ex)).
     - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1, lasting exactly 1 cycle per load.
- Simultaneous dram_req without ack and a branch in RUN: the freeze wins combinationally in that same cycle.
  - The freeze applies in the entry cycle as well: stall outputs are asserted whenever (state==RUN & dram_req & ~dram_ack) or state!=RUN.
- Forwarding, computed every cycle regardless of state:
  - fwd_a_sel=01 if valid_mem & rf_we_mem & wR_mem!=0 & wR_mem==rs1_ex.
  - Otherwise fwd_a_sel=10 if valid_wb & rf_we_wb & wR_wb!=0 & wR_wb==rs1_ex.
  - Otherwise fwd_a_sel=00.
  - fwd_b_sel is computed identically using rs2_ex.
  - x0 is never forwarded.
- stall_cycles: increments by 1 on every clock edge where stall_pc=1; saturates at all-ones.
- dram_err: set on entry to ERR; cleared only by reset.

Test Plan:
- Load x5 in EX (wd_sel_ex=01), ID reads rs1=x5 with re1_id=1 -> stall_pc, stall_if_id and flush_id_ex are 1 for exactly one cycle; next cycle fwd_a_sel=10 when the load reaches WB and rs1_ex=x5.
- ALU writes x3 in MEM and x3 also in WB, rs2_ex=x3 -> fwd_b_sel=01 (MEM wins); with wR_mem=x0 -> fwd_b_sel=10; with rs2_ex=x0 -> 00.
- dram_req=1 with ack returned after 3 cycles -> all stall_* and flush_mem_wb high for 3 cycles, state back to RUN, stall_cycles=3.
- br_taken_ex=1 coincident with a load-use condition -> flush_if_id=1, flush_id_ex=1, stall_pc=0.
- dram_req held with no ack for TIMEOUT=16 cycles -> ERR, dram_err=1, pipeline frozen; later dram_ack has no effect; reset clears it.
- Reset asserted mid-MEM_WAIT -> outputs go to 0 immediately; after release the state is RUN and stall_cycles=0.
